// File: rtl/score_bcd_display.sv
// Iterative binary-to-BCD converter driving active-low 7-segment digits, with
// leading-zero blanking and overflow saturation. Optional blink: SCORE_BLINK_EN.
module score_bcd_display #(
  parameter int BIN_W   = 8,
  parameter int DIGITS  = 3,
  parameter int BLINK_W = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [BIN_W-1:0]      score,
  input  logic                  blank_lz,
  input  logic                  game_over,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out
);

  // state    | meaning
  // ST_IDLE  | waiting for load; displayed result held
  // ST_SHIFT | one double-dabble step per cycle, BIN_W cycles
  // ST_DONE  | new result visible, done pulses for this cycle
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               ovf_work_q, ovf_work_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_sh;
  logic [BIN_W-1:0]   bin_sh;
  logic               carry_out;
  logic               ovf_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction ahead of the shift; the bit leaving the top digit means
  // the score has a digit beyond what we can display.
  always_comb begin
    work_adj = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) begin
        work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
      end
    end
    carry_out = work_adj[BCD_W-1];
    work_sh   = {work_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_sh    = bin_q << 1;
    ovf_next  = ovf_work_q | carry_out;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    work_d     = work_q;
    ovf_work_d = ovf_work_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d      = score;
          work_d     = '0;
          ovf_work_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d     = work_sh;
        bin_d      = bin_sh;
        ovf_work_d = ovf_next;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish on entry to DONE so outputs are valid alongside done.
          cnt_d   = '0;
          state_d = ST_DONE;
          bcd_d   = ovf_next ? {DIGITS{4'h9}} : work_sh;
          ovf_d   = ovf_next;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      ovf_work_q <= ovf_work_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef SCORE_BLINK_EN
  logic [BLINK_W-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q + BLINK_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  logic [BLINK_W-1:0] unused_blink;
  assign unused_blink = {BLINK_W{game_over}};
`endif

  logic [7*DIGITS-1:0] hex_comb;
  logic                zero_run;
  logic [6:0]          seg_k;

  // Walk from the top digit down; a digit blanks only while everything above
  // it (and itself) is zero.
  always_comb begin
    hex_comb = '1;
    zero_run = 1'b1;
    seg_k    = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (bcd_q[4*k +: 4] == 4'd0);
      seg_k    = seg7(bcd_q[4*k +: 4]);
      if ((k != 0) && blank_lz && zero_run) begin
        seg_k = 7'b1111111;
      end
      hex_comb[7*k +: 7] = seg_k;
    end
`ifdef SCORE_BLINK_EN
    if (game_over && blink_q[BLINK_W-1]) begin
      hex_comb = '1;
    end
`endif
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign ovf     = ovf_q;
  assign bcd_out = bcd_q;
  assign hex_out = hex_comb;

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: a 3-digit and a 2-digit instance share stimulus and
// are checked every cycle against an arithmetic model, plus directed literal checks.
module tb_score_bcd_display;
  localparam int BIN_W   = 8;
  localparam int BLINK_W = 4;
  localparam int MAX1    = 999;
  localparam int MAX2    = 99;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic load = 1'b0;
  logic [BIN_W-1:0] score = '0;
  logic blank_lz = 1'b0;
  logic game_over = 1'b0;

  logic busy1, done1, ovf1, busy2, done2, ovf2;
  logic [11:0] bcd1;
  logic [20:0] hex1;
  logic [7:0]  bcd2;
  logic [13:0] hex2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_bcd_display #(.BIN_W(BIN_W), .DIGITS(3), .BLINK_W(BLINK_W)) dut1 (
    .clk(clk), .resetn(resetn), .load(load), .score(score), .blank_lz(blank_lz),
    .game_over(game_over), .busy(busy1), .done(done1), .ovf(ovf1),
    .bcd_out(bcd1), .hex_out(hex1));

  score_bcd_display #(.BIN_W(BIN_W), .DIGITS(2), .BLINK_W(BLINK_W)) dut2 (
    .clk(clk), .resetn(resetn), .load(load), .score(score), .blank_lz(blank_lz),
    .game_over(game_over), .busy(busy2), .done(done2), .ovf(ovf2),
    .bcd_out(bcd2), .hex_out(hex2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_bcd(input int val, input int nd);
    logic [15:0] b = '0;
    int v = val;
    for (int k = 0; k < nd; k++) begin
      b[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic logic [27:0] exp_hex(input int val, input int nd, input bit bl, input bit dark);
    logic [27:0] h = '1;
    int v = val;
    int p = 1;
    logic [6:0] s;
    for (int k = 0; k < nd; k++) begin
      s = SEG[v % 10];
      if (k > 0 && bl && val < p) s = 7'h7F;
      if (dark) s = 7'h7F;
      h[7*k +: 7] = s;
      v = v / 10;
      p = p * 10;
    end
    return h;
  endfunction

  // Model: a conversion is a countdown of BIN_W+1 cycles; the result appears
  // when one cycle remains (the done cycle).
  int m_left = 0;
  int m_score = 0;
  int m_val1 = 0, m_val2 = 0;
  bit m_ovf1 = 0, m_ovf2 = 0;
  int m_blink = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left  <= 0;
      m_val1  <= 0;
      m_val2  <= 0;
      m_ovf1  <= 0;
      m_ovf2  <= 0;
      m_blink <= 0;
    end else begin
      m_blink <= (m_blink + 1) % (1 << BLINK_W);
      if (m_left == 0) begin
        if (load) begin
          m_left  <= BIN_W + 1;
          m_score <= int'(score);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_ovf1 <= (m_score > MAX1);
          m_val1 <= (m_score > MAX1) ? MAX1 : m_score;
          m_ovf2 <= (m_score > MAX2);
          m_val2 <= (m_score > MAX2) ? MAX2 : m_score;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit dark;
    logic [27:0] eh1, eh2;
`ifdef SCORE_BLINK_EN
    dark = game_over && (((m_blink >> (BLINK_W - 1)) & 1) != 0);
`else
    dark = 1'b0;
`endif
    eh1 = exp_hex(m_val1, 3, blank_lz, dark);
    eh2 = exp_hex(m_val2, 2, blank_lz, dark);
    chk("busy1", 32'(busy1), 32'(m_left != 0));
    chk("done1", 32'(done1), 32'(m_left == 1));
    chk("ovf1",  32'(ovf1),  32'(m_ovf1));
    chk("bcd1",  32'(bcd1),  32'(exp_bcd(m_val1, 3)));
    chk("hex1",  32'(hex1),  32'(eh1[20:0]));
    chk("busy2", 32'(busy2), 32'(m_left != 0));
    chk("done2", 32'(done2), 32'(m_left == 1));
    chk("ovf2",  32'(ovf2),  32'(m_ovf2));
    chk("bcd2",  32'(bcd2),  32'(exp_bcd(m_val2, 2)));
    chk("hex2",  32'(hex2),  32'(eh2[13:0]));
  end

  // Issues one load and returns at the done cycle (lat = cycle index of done,
  // 0 if it never came within the budget).
  task automatic run_conv(input logic [7:0] s, input logic bl, output int lat);
    @(negedge clk); #2;
    load = 1'b1; score = s; blank_lz = bl;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done1 && lat == 0) lat = c;
      #2 load = 1'b0;
      if (lat != 0) break;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int pick;
    repeat (3) @(negedge clk);
    #1 chk("rst_bcd1", 32'(bcd1), 32'h000);
    chk("rst_hex1", 32'(hex1), 32'({7'b1000000, 7'b1000000, 7'b1000000}));
    #1 resetn = 1'b1;

    // Test 1
    run_conv(8'd32, 1'b1, lat);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_bcd", 32'(bcd1), 32'h032);
    chk("t1_ovf", 32'(ovf1), 32'd0);
    chk("t1_hex", 32'(hex1), 32'({7'b1111111, 7'b0110000, 7'b0100100}));

    // Test 2
    run_conv(8'd255, 1'b0, lat);
    chk("t2_bcd255", 32'(bcd1), 32'h255);
    run_conv(8'd0, 1'b1, lat);
    chk("t2_hex0", 32'(hex1), 32'({7'b1111111, 7'b1111111, 7'b1000000}));

    // Test 3 (2-digit instance saturates)
    run_conv(8'd200, 1'b1, lat);
    chk("t3_ovf2", 32'(ovf2), 32'd1);
    chk("t3_bcd2", 32'(bcd2), 32'h99);
    chk("t3_bcd1", 32'(bcd1), 32'h200);
    chk("t3_hex2", 32'(hex2), 32'({7'b0010000, 7'b0010000}));
    run_conv(8'd42, 1'b1, lat);
    chk("t3_ovf2b", 32'(ovf2), 32'd0);
    chk("t3_bcd2b", 32'(bcd2), 32'h42);

    // Test 4: a second load during SHIFT is ignored
    @(negedge clk); #2;
    load = 1'b1; score = 8'd123;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done1) ndone++;
      #2;
      load = (c == 3);
      score = (c >= 3) ? 8'd99 : 8'd123;
    end
    load = 1'b0;
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_bcd", 32'(bcd1), 32'h123);

    // Test 5: reset in the middle of SHIFT
    @(negedge clk); #2;
    load = 1'b1; score = 8'd77; blank_lz = 1'b0;
    @(posedge clk);
    repeat (4) @(negedge clk);
    #2 load = 1'b0; resetn = 1'b0;
    #1 chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_bcd", 32'(bcd1), 32'h000);
    chk("t5_hex", 32'(hex1), 32'({7'b1000000, 7'b1000000, 7'b1000000}));
    @(negedge clk); #2 resetn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    chk("t5_nodone", 32'(ndone), 32'd0);
    run_conv(8'd58, 1'b1, lat);
    chk("t5_latency", 32'(lat), 32'd9);
    chk("t5_bcd_after", 32'(bcd1), 32'h058);

    // Randomized traffic, boundary-weighted scores
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #2;
      load = ($urandom_range(0, 3) == 0);
      pick = $urandom_range(0, 9);
      case (pick)
        0: score = 8'd0;
        1: score = 8'd9;
        2: score = 8'd10;
        3: score = 8'd99;
        4: score = 8'd100;
        5: score = 8'd255;
        default: score = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 15) == 0) game_over = ~game_over;
    end
    load = 1'b0;
    repeat (12) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
